// File: rtl/button_event_scheduler.sv
// rtl/button_event_scheduler.sv - round-robin scheduler turning button press pulses into an ordered event FIFO
// Auto-repeat of a lone held button is built only when BTN_AUTOREPEAT_EN is defined.
module button_event_scheduler #(
  parameter int N_BTN        = 5,
  parameter int DEPTH        = 4,
  parameter int HOLD_TICKS   = 50,
  parameter int REPEAT_TICKS = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_BTN-1:0]         btn_pulse,
  input  logic [N_BTN-1:0]         btn_level,
  input  logic                     tick_en,
  input  logic                     evt_ready,
  output logic                     evt_valid,
  output logic [$clog2(N_BTN)-1:0] evt_id,
  output logic                     evt_repeat,
  output logic [$clog2(DEPTH):0]   evt_count,
  output logic                     overrun
);
  localparam int IW = $clog2(N_BTN);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [N_BTN-1:0] pending_q, pending_d;
  logic [IW-1:0]    rr_q, rr_d;
  logic             overrun_q, overrun_d;
  logic [IW-1:0]    mem_id_q [DEPTH];
  logic [IW-1:0]    mem_id_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [N_BTN-1:0] rep_req;
  logic             full, push, pop;
  logic [IW-1:0]    gnt_idx;

`ifdef BTN_AUTOREPEAT_EN
  localparam int HW = $clog2(HOLD_TICKS + REPEAT_TICKS + 1);

  logic [N_BTN-1:0] rep_flag_q, rep_flag_d;
  logic             mem_rep_q [DEPTH];
  logic             mem_rep_d [DEPTH];
  logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
  logic [N_BTN-1:0] level_q, level_d;

  // Counter parks at HOLD_TICKS after each repeat so it never needs to grow past one period.
  always_comb begin
    rep_req    = '0;
    hold_cnt_d = hold_cnt_q;
    level_d    = btn_level;
    if (btn_level != level_q || !$onehot(btn_level)) begin
      hold_cnt_d = '0;
    end else if (tick_en) begin
      hold_cnt_d = hold_cnt_q + HW'(1);
      if (hold_cnt_d == HW'(HOLD_TICKS)) begin
        rep_req = btn_level;
      end else if (hold_cnt_d == HW'(HOLD_TICKS + REPEAT_TICKS)) begin
        rep_req    = btn_level;
        hold_cnt_d = HW'(HOLD_TICKS);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rep_flag_q <= '0;
      mem_rep_q  <= '{default: 1'b0};
      hold_cnt_q <= '0;
      level_q    <= '0;
    end else begin
      rep_flag_q <= rep_flag_d;
      mem_rep_q  <= mem_rep_d;
      hold_cnt_q <= hold_cnt_d;
      level_q    <= level_d;
    end
  end

  assign evt_repeat = mem_rep_q[rd_ptr_q];
`else
  logic unused_inputs;
  assign unused_inputs = ^{btn_level, tick_en};
  assign rep_req       = '0;
  assign evt_repeat    = 1'b0;
`endif

  always_comb begin
    int            j;
    logic [IW-1:0] jj;
    j       = 0;
    jj      = '0;
    gnt_idx = '0;
    push    = 1'b0;
    full    = (count_q == CW'(DEPTH));
    pop     = (count_q != '0) && evt_ready;
    // Search starts just after the last grant, so the last winner has lowest priority.
    for (int k = 1; k <= N_BTN; k++) begin
      j = int'(rr_q) + k;
      if (j >= N_BTN) j = j - N_BTN;
      jj = IW'(j);
      if (!full && !push && pending_q[jj]) begin
        push    = 1'b1;
        gnt_idx = jj;
      end
    end

    mem_id_d = mem_id_q;
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    rr_d     = push ? gnt_idx : rr_q;
    if (push) mem_id_d[wr_ptr_q] = gnt_idx;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    pending_d = pending_q;
    overrun_d = overrun_q;
    if (push) pending_d[gnt_idx] = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
    mem_rep_d  = mem_rep_q;
    rep_flag_d = rep_flag_q;
    if (push) mem_rep_d[wr_ptr_q] = rep_flag_q[gnt_idx];
`endif
    // New requests are applied after the grant clear so a same-cycle set survives.
    for (int i = 0; i < N_BTN; i++) begin
      if (btn_pulse[i]) begin
        if (pending_q[i]) overrun_d = 1'b1;
        pending_d[i] = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
        rep_flag_d[i] = 1'b0;
`endif
      end else if (rep_req[i]) begin
        if (pending_q[i]) begin
          overrun_d = 1'b1;
        end else begin
          pending_d[i] = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
          rep_flag_d[i] = 1'b1;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      rr_q      <= IW'(N_BTN - 1);
      overrun_q <= 1'b0;
      mem_id_q  <= '{default: '0};
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      pending_q <= pending_d;
      rr_q      <= rr_d;
      overrun_q <= overrun_d;
      mem_id_q  <= mem_id_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  assign evt_valid = (count_q != '0);
  assign evt_id    = mem_id_q[rd_ptr_q];
  assign evt_count = count_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_button_event_scheduler.sv
// tb/tb_button_event_scheduler.sv - bench for button_event_scheduler: vector table, hold sequence, random run vs queue model
module tb_button_event_scheduler;
  localparam int N = 5;
  localparam int D = 4;
  localparam int H = 3;
  localparam int R = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] btn_pulse, btn_level;
  logic       tick_en, evt_ready;
  logic       evt_valid, evt_repeat, overrun;
  logic [2:0] evt_id;
  logic [2:0] evt_count;

  button_event_scheduler #(
    .N_BTN(N), .DEPTH(D), .HOLD_TICKS(H), .REPEAT_TICKS(R)
  ) dut (
    .clk(clk), .rst(rst), .btn_pulse(btn_pulse), .btn_level(btn_level),
    .tick_en(tick_en), .evt_ready(evt_ready), .evt_valid(evt_valid),
    .evt_id(evt_id), .evt_repeat(evt_repeat), .evt_count(evt_count),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct { int id; logic rep; } evt_t;
  evt_t       mq[$];
  logic       pend[N];
  logic       mrep[N];
  int         rr;
  logic       movr;
  logic [4:0] prev_lvl;
  int         held;

  typedef struct {
    logic r; logic [4:0] p; logic rdy;
    logic v; logic [2:0] id; logic [2:0] cnt; logic ovr;
  } vec_t;
  vec_t tbl[$];

  typedef struct { int cyc; int id; logic rep; } obs_t;
  obs_t seen[$];
  obs_t want[$];

  function automatic vec_t mk(logic r, logic [4:0] p, logic rdy, logic v,
                              logic [2:0] id, logic [2:0] cnt, logic ovr);
    vec_t t;
    t.r = r; t.p = p; t.rdy = rdy; t.v = v; t.id = id; t.cnt = cnt; t.ovr = ovr;
    return t;
  endfunction

  function automatic obs_t ob(int c, int id, logic rep);
    obs_t o;
    o.cyc = c; o.id = id; o.rep = rep;
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: one clock edge expressed as queue operations on the pre-edge state.
  task automatic model_step(input logic r, input logic [4:0] p, input logic [4:0] lvl,
                            input logic tk, input logic rdy);
    logic       old[N];
    logic [4:0] rq;
    int         gnt;
    if (r) begin
      mq.delete();
      for (int i = 0; i < N; i++) begin pend[i] = 0; mrep[i] = 0; end
      rr = N - 1; movr = 0; prev_lvl = '0; held = 0;
      return;
    end
    rq = '0;
`ifdef BTN_AUTOREPEAT_EN
    if (lvl == prev_lvl && $countones(lvl) == 1) begin
      if (tk) begin
        held++;
        if (held == H || (held > H && (held - H) % R == 0)) rq = lvl;
      end
    end else begin
      held = 0;
    end
`endif
    prev_lvl = lvl;
    old = pend;
    gnt = -1;
    if (mq.size() < D)
      for (int k = 1; k <= N; k++)
        if (gnt < 0 && pend[(rr + k) % N]) gnt = (rr + k) % N;
    if (mq.size() > 0 && rdy) void'(mq.pop_front());
    if (gnt >= 0) begin
      evt_t e;
      e.id = gnt; e.rep = mrep[gnt];
      mq.push_back(e);
      pend[gnt] = 0;
      rr = gnt;
    end
    for (int i = 0; i < N; i++) begin
      if (p[i]) begin
        if (old[i]) movr = 1;
        pend[i] = 1; mrep[i] = 0;
      end else if (rq[i]) begin
        if (old[i]) movr = 1;
        else begin pend[i] = 1; mrep[i] = 1; end
      end
    end
  endtask

  task automatic check_model();
    check("model_valid", evt_valid, mq.size() != 0);
    check("model_count", evt_count, mq.size());
    check("model_overrun", overrun, movr);
    if (mq.size() != 0) begin
      check("model_id", evt_id, mq[0].id);
      check("model_repeat", evt_repeat, mq[0].rep);
    end
  endtask

  task automatic do_cycle(input logic r, input logic [4:0] p, input logic [4:0] lvl,
                          input logic tk, input logic rdy);
    rst = r; btn_pulse = p; btn_level = lvl; tick_en = tk; evt_ready = rdy;
    model_step(r, p, lvl, tk, rdy);
    @(posedge clk);
    #1;
    check_model();
  endtask

  initial begin
    int         cyc;
    logic [4:0] lvl, p;

    rst = 1'b1; btn_pulse = '0; btn_level = '0; tick_en = 1'b0; evt_ready = 1'b0;
    do_cycle(1, '0, '0, 0, 0);
    check("reset_valid", evt_valid, 0);
    check("reset_count", evt_count, 0);
    check("reset_overrun", overrun, 0);
    check("reset_repeat", evt_repeat, 0);

    // single press
    tbl.push_back(mk(0, 5'b00100, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 5'b00000, 1, 1, 2, 1, 0));
    tbl.push_back(mk(0, 5'b00000, 1, 0, 0, 0, 0));
    // simultaneous presses, then again with rr at 4
    tbl.push_back(mk(1, 5'b00000, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 5'b10011, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 5'b00000, 1, 1, 0, 1, 0));
    tbl.push_back(mk(0, 5'b00000, 1, 1, 1, 1, 0));
    tbl.push_back(mk(0, 5'b00000, 1, 1, 4, 1, 0));
    tbl.push_back(mk(0, 5'b10001, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 5'b00000, 1, 1, 0, 1, 0));
    tbl.push_back(mk(0, 5'b00000, 1, 1, 4, 1, 0));
    tbl.push_back(mk(0, 5'b00000, 1, 0, 0, 0, 0));
    // backpressure: fill, hold button 4 pending, merge, drain
    tbl.push_back(mk(1, 5'b00000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 5'b00001, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 5'b00010, 0, 1, 0, 1, 0));
    tbl.push_back(mk(0, 5'b00100, 0, 1, 0, 2, 0));
    tbl.push_back(mk(0, 5'b01000, 0, 1, 0, 3, 0));
    tbl.push_back(mk(0, 5'b10000, 0, 1, 0, 4, 0));
    tbl.push_back(mk(0, 5'b00000, 0, 1, 0, 4, 0));
    tbl.push_back(mk(0, 5'b10000, 0, 1, 0, 4, 1));
    tbl.push_back(mk(0, 5'b00000, 1, 1, 1, 3, 1));
    tbl.push_back(mk(0, 5'b00000, 1, 1, 2, 3, 1));
    tbl.push_back(mk(0, 5'b00000, 1, 1, 3, 2, 1));
    tbl.push_back(mk(0, 5'b00000, 1, 1, 4, 1, 1));
    tbl.push_back(mk(0, 5'b00000, 1, 0, 0, 0, 1));
    // reset with 3+ queued and one pending
    tbl.push_back(mk(1, 5'b00000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 5'b00111, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 5'b00000, 0, 1, 0, 1, 0));
    tbl.push_back(mk(0, 5'b01000, 0, 1, 0, 2, 0));
    tbl.push_back(mk(0, 5'b00000, 0, 1, 0, 3, 0));
    tbl.push_back(mk(0, 5'b01000, 0, 1, 0, 4, 1));
    tbl.push_back(mk(1, 5'b00000, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 5'b00000, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 5'b00000, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 5'b00000, 1, 0, 0, 0, 0));

    for (int n = 0; n < tbl.size(); n++) begin
      do_cycle(tbl[n].r, tbl[n].p, '0, 0, tbl[n].rdy);
      check($sformatf("vec%0d_valid", n), evt_valid, tbl[n].v);
      check($sformatf("vec%0d_count", n), evt_count, tbl[n].cnt);
      check($sformatf("vec%0d_overrun", n), overrun, tbl[n].ovr);
      check($sformatf("vec%0d_repeat", n), evt_repeat, 0);
      if (tbl[n].v) check($sformatf("vec%0d_id", n), evt_id, tbl[n].id);
    end

    // hold button 1 with a tick every 4th cycle, release, then hold buttons 1 and 2
    do_cycle(1, '0, '0, 0, 1);
    for (cyc = 0; cyc < 80; cyc++) begin
      lvl = (cyc < 32) ? 5'b00010 : (cyc < 48) ? 5'b00000 : 5'b00110;
      do_cycle(0, (cyc == 0) ? 5'b00010 : 5'b00000, lvl, (cyc % 4) == 3, 1);
      if (evt_valid) seen.push_back(ob(cyc, evt_id, evt_repeat));
    end
    want.push_back(ob(1, 1, 0));
`ifdef BTN_AUTOREPEAT_EN
    want.push_back(ob(12, 1, 1));
    want.push_back(ob(20, 1, 1));
    want.push_back(ob(28, 1, 1));
`endif
    check("hold_event_count", seen.size(), want.size());
    for (int n = 0; n < want.size() && n < seen.size(); n++) begin
      check($sformatf("hold_evt%0d_cycle", n), seen[n].cyc, want[n].cyc);
      check($sformatf("hold_evt%0d_id", n), seen[n].id, want[n].id);
      check($sformatf("hold_evt%0d_repeat", n), seen[n].rep, want[n].rep);
    end

    lvl = '0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        case ($urandom_range(0, 3))
          0:       lvl = '0;
          3:       lvl = 5'($urandom_range(0, 31));
          default: lvl = 5'(1 << $urandom_range(0, 4));
        endcase
      end
      p = '0;
      for (int i = 0; i < N; i++) if ($urandom_range(0, 9) == 0) p[i] = 1'b1;
      do_cycle($urandom_range(0, 299) == 0, p, lvl, $urandom_range(0, 2) == 0,
               $urandom_range(0, 2) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/button_event_scheduler.md
Name: button_event_scheduler

Overview:
- Collects one-cycle press pulses from several push-button detector instances (up/down/left/right/centre) and schedules them into a single ordered event stream for the time/alarm-set FSM.
- Stream uses a valid/ready handshake.
- Simultaneous presses are resolved by round-robin arbitration and buffered in a small FIFO.
- Optional auto-repeat generates repeated events while one button is held.

Parameters:
- N_BTN, 5, number of button inputs (2..8).
- DEPTH, 4, event FIFO depth (power of two, ≥2).
- HOLD_TICKS, 50, tick_en pulses a lone button must be held before the first repeat (0.5 s at 100 Hz).
- REPEAT_TICKS, 10, tick_en pulses between subsequent repeats.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- btn_pulse  in  N_BTN  one-cycle press pulses, already debounced/synchronized/edge-detected
- btn_level  in  N_BTN  synchronized held levels (used only by auto-repeat)
- tick_en  in  1  one-cycle timebase strobe (100 Hz)
- evt_ready  in  1  consumer accepts head event
- evt_valid  out  1  FIFO non-empty
- evt_id  out  $clog2(N_BTN)  button index of head event
- evt_repeat  out  1  head event was produced by auto-repeat
- evt_count  out  $clog2(DEPTH)+1  FIFO occupancy
- overrun  out  1  sticky: a request was merged or lost

Behaviour:
- Clock and reset: one clock, clk. Reset is rst, synchronous, active-high. While rst is high at a clk edge, all state clears:
  - evt_valid=0, evt_id=0, evt_repeat=0, evt_count=0, overrun=0.
  - pending vector 0, repeat flags 0, rr pointer = N_BTN-1 (index 0 has first priority), hold counter 0.
  - Reset mid-operation discards queued and pending events with no partial output.
- Pending capture: each edge, pending[i] is set by btn_pulse[i] (or by a repeat request). A pulse arriving while pending[i] is already set is merged and sets overrun. If a set and a grant-clear hit the same bit in the same cycle, the set wins and the bit stays 1. A real pulse sets rep_flag[i]=0, and that takes priority over a repeat in the same cycle.
- Arbitration: each cycle, if the FIFO is not full and pending≠0, grant the first set bit searching from rr+1 upward, wrapping modulo N_BTN. On grant:
  - push {idx, rep_flag[idx]};
  - clear pending[idx];
  - rr←idx.
  - At most one push per cycle.
- Full handling: full is evaluated from current occupancy. No push occurs when full, even if a pop happens in the same cycle, so pending holds the request.
- FIFO: circular buffer with read/write pointers wrapping at DEPTH.
  - evt_valid = (count≠0); evt_id and evt_repeat are driven from the head entry.
  - A pop occurs when evt_valid && evt_ready.
  - Simultaneous push and pop (not full): count unchanged.
  - evt_ready while empty: no effect.
  - Head outputs hold steady while evt_valid && !evt_ready.
- Latency: a pulse in cycle t sets pending at edge t+1 and is pushed at edge t+2, so evt_valid is seen in cycle t+2 when uncontended and the FIFO is not full.
- overrun: set by a merged pulse or a dropped repeat. Cleared only by rst.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- Defined:
  - Hold tracker is active when btn_level is exactly one-hot; it counts tick_en pulses.
  - The counter resets to 0 when btn_level changes, is zero, or has multiple bits set.
  - When the count reaches HOLD_TICKS, issue a repeat request for that button, then one every REPEAT_TICKS ticks while the hold continues.
  - A repeat request sets pending[i] and rep_flag[i]=1. If pending[i] is already set, the repeat is dropped and overrun is set.
- Undefined:
  - No hold logic is synthesized; btn_level and tick_en are unused.
  - evt_repeat is constant 0, and rep_flag is absent.

Test Plan:
- Single press: btn_pulse=5'b00100 for 1 cycle with evt_ready=1 → evt_valid=1 exactly 2 cycles later for 1 cycle; evt_id=2, evt_repeat=0, evt_count returns to 0.
- Simultaneous presses: btn_pulse=5'b10011 after reset with evt_ready=1 → events in order id 0, 1, 4 on consecutive cycles. Then with rr=4, btn_pulse=5'b10001 → order 0, 4.
- Backpressure: evt_ready=0, press buttons 0,1,2,3,4 one per cycle →
  - evt_count saturates at 4 with ids 0,1,2,3 queued; button 4 stays pending.
  - A second pulse on button 4 sets overrun=1.
  - Raising evt_ready drains 0,1,2,3,4.
- Reset mid-operation: 3 events queued plus 1 pending, rst high for 1 cycle → next cycle evt_valid=0, evt_count=0, overrun=0; no stale event ever appears.
- Auto-repeat (BTN_AUTOREPEAT_EN defined, HOLD_TICKS=3, REPEAT_TICKS=2): press button 1 (pulse plus level held) with tick_en every 4th cycle →
  - one event with evt_repeat=0;
  - then evt_repeat=1 after the 3rd tick, the 5th tick, the 7th tick, and so on;
  - releasing, or also holding button 2, stops repeats and resets the counter.
- Macro undefined: same auto-repeat stimulus → only the single press event; evt_repeat stays 0.
